hazard_detection_unit: RTL

Stall/flush controller for the 5-stage pipeline CPU; it acts as the control end of the EX→ID bypass path. Where the forwarding path cannot resolve a dependence (load-use), it holds PC and IF/ID and injects an ID/EX bubble. It flushes on taken branches and freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a watchdog. It sits beside the ID stage and drives the write enables of the PC and pipeline registers.

---
 rtl/hazard_detection_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stall, branch flush,
// data-memory freeze with watchdog. Optional stall counter enabled by STALL_CNT_EN.
module hazard_detection_unit #(
  parameter int unsigned register_addr = 5,
  parameter int unsigned mem_timeout   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_r_pip,
  input  logic [register_addr-1:0] wb_addr_pip,
  input  logic [register_addr-1:0] rs_id,
  input  logic [register_addr-1:0] rt_id,
  input  logic                     rt_used_id,
  input  logic                     branch_taken,
  input  logic                     dmem_req,
  input  logic                     dmem_ack,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     idex_bubble,
  output logic                     ifid_flush,
  output logic                     pipe_freeze,
  output logic                     mem_err,
  output logic [15:0]              stall_cnt
);

  localparam int unsigned WD_W  = 16;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            mem_err_q, mem_err_nxt;
  logic            lu, mp, timeout;

  // Hazard conditions
  always_comb begin
    lu = mem_r_pip && (wb_addr_pip != '0) &&
         ((wb_addr_pip == rs_id) || (rt_used_id && (wb_addr_pip == rt_id)));
    timeout = (state == MEM_WAIT) && !dmem_ack && (wd == WD_W'(mem_timeout - 1));
    // the watchdog expiry cycle releases the freeze
    mp = ((state == RUN) && dmem_req && !dmem_ack) ||
         ((state == MEM_WAIT) && !dmem_ack && !timeout);
  end

  // Next state and prioritised control outputs
  always_comb begin
    state_nxt   = state;
    wd_nxt      = wd;
    mem_err_nxt = mem_err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    mem_err     = mem_err_q && !rst;

    case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          state_nxt = MEM_WAIT;
          wd_nxt    = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt = RUN;
        end else if (timeout) begin
          state_nxt   = RUN;
          mem_err_nxt = 1'b1;
        end else begin
          wd_nxt = wd + WD_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase

    if (rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end else if (mp) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wd        <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd        <= wd_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!pc_write && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = rst ? '0 : cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
